// File: rtl/nibble_serial_add_seq_if.sv
// Handshake and adder-stage bundle for nibble_serial_add_seq.
// The slave modport is the sequencer's view; the master modport is the surrounding logic's view.
interface nibble_serial_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/nibble_serial_add_seq.sv
// Streams a WIDTH-bit add through an external 4-bit adder, one nibble per cycle, LSB first.
// Define NIBBLE_SEQ_OVF_EN to build the signed-overflow register behind out_ovf.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// RUN    | feeding nibble idx to the adder and capturing its sum/carry
// DONE   | result presented on out_valid until out_ready
module nibble_serial_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_add_seq_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IDX_W+1:0] bit_base;
    logic             run, done;

    assign run      = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign bit_base = {idx_q, 2'b00};

`ifdef NIBBLE_SEQ_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef NIBBLE_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    res_d   = '0;
`ifdef NIBBLE_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[bit_base +: 4] = bus.add_sum;
                carry_d              = bus.add_cout;
                if (idx_q == LAST_IDX) begin
`ifdef NIBBLE_SEQ_OVF_EN
                    // Top nibble's sum bit 3 is the result sign bit.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bus.add_sum[3] != a_q[WIDTH-1]);
`endif
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
`ifdef NIBBLE_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
`ifdef NIBBLE_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = run || done;
    assign bus.add_a     = run ? a_q[bit_base +: 4] : 4'h0;
    assign bus.add_b     = run ? b_q[bit_base +: 4] : 4'h0;
    assign bus.add_cin   = run && carry_q;
    assign bus.out_valid = done;
    assign bus.out_sum   = done ? res_q : '0;
    assign bus.out_cout  = done && carry_q;
`ifdef NIBBLE_SEQ_OVF_EN
    assign bus.out_ovf   = done && ovf_q;
`else
    assign bus.out_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq with a 4-bit carry-skip adder stage and an arithmetic reference model.
module tb_nibble_serial_add_seq;
    localparam int W = 16;
    localparam int N = W / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_add_seq_if #(.WIDTH(W)) bus ();

    nibble_serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 4-bit carry-skip adder: ripple carries, bypassed when all bits propagate.
    logic [3:0] p, g;
    logic [4:0] c;
    always_comb begin
        p = bus.add_a ^ bus.add_b;
        g = bus.add_a & bus.add_b;
        c = '0;
        c[0] = bus.add_cin;
        for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
        bus.add_sum  = p ^ c[3:0];
        bus.add_cout = (&p) ? bus.add_cin : c[4];
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endfunction

`ifdef NIBBLE_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    function automatic logic [16:0] full_sum(input logic [15:0] a, input logic [15:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + 17'(ci);
    endfunction

    function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b, input logic ci, input int k);
        logic [31:0] m, s;
        if (k == 0) return ci;
        m = (32'd1 << (4 * k)) - 32'd1;
        s = (32'(a) & m) + (32'(b) & m) + 32'(ci);
        return s[4*k];
    endfunction

    function automatic logic ovf_of(input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] s;
        s = full_sum(a, b, ci);
        return OVF_EN && (a[15] == b[15]) && (s[15] != a[15]);
    endfunction

    // Reference model / compare process, sampled on the falling edge.
    int          cyc = 0;
    bit          active = 1'b0;
    int          acc_cyc;
    logic [15:0] m_a, m_b;
    logic        m_cin;
    logic [15:0] last_sum;
    logic        last_cout, last_ovf;
    logic [3:0]  run_cin;

    always @(negedge clk) begin
        logic [16:0] s;
        int k;
        cyc++;
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_out_sum", bus.out_sum, 0);
            chk("rst_out_cout", bus.out_cout, 0);
            chk("rst_out_ovf", bus.out_ovf, 0);
            active = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, !active);
            chk("busy", bus.busy, active);
            if (active) begin
                k = cyc - acc_cyc - 1;
                if (k < N) begin
                    chk("run_out_valid", bus.out_valid, 0);
                    chk("run_add_a", bus.add_a, m_a[4*k +: 4]);
                    chk("run_add_b", bus.add_b, m_b[4*k +: 4]);
                    chk("run_add_cin", bus.add_cin, carry_into(m_a, m_b, m_cin, k));
                    run_cin[k] = bus.add_cin;
                end else begin
                    s = full_sum(m_a, m_b, m_cin);
                    chk("done_out_valid", bus.out_valid, 1);
                    chk("out_sum", bus.out_sum, s[15:0]);
                    chk("out_cout", bus.out_cout, s[16]);
                    chk("out_ovf", bus.out_ovf, ovf_of(m_a, m_b, m_cin));
                    chk("done_add_a", {bus.add_a, bus.add_b, bus.add_cin}, 0);
                    if (bus.out_ready) begin
                        last_sum  = bus.out_sum;
                        last_cout = bus.out_cout;
                        last_ovf  = bus.out_ovf;
                        active    = 1'b0;
                    end
                end
            end else begin
                chk("idle_out_valid", bus.out_valid, 0);
                chk("idle_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);
                chk("idle_out_ovf", bus.out_ovf, 0);
                if (bus.in_valid && bus.in_ready) begin
                    active  = 1'b1;
                    acc_cyc = cyc;
                    m_a     = bus.in_a;
                    m_b     = bus.in_b;
                    m_cin   = bus.in_cin;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input int hold, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("timeout_in_ready", 1, 0);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = ci;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin step(); lat++; end
        if (lat >= 20) chk("timeout_out_valid", 1, 0);
        if (hold > 0) begin
            bus.in_valid = 1'b1; bus.in_a = ~a; bus.in_b = ~b;
            for (int i = 0; i < hold; i++) begin
                chk("hold_in_ready", bus.in_ready, 0);
                step();
            end
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if (hold > 0) chk("ready_after_release", bus.in_ready, 1);
        step();
    endtask

    initial begin
        int lat, n;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
        bus.out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        do_op(16'h1234, 16'h4321, 1'b0, 0, lat);
        chk("lit_latency", lat, N);
        chk("lit_1234_sum", last_sum, 16'h5555);
        chk("lit_1234_cout", last_cout, 0);

        do_op(16'hFFFF, 16'h0001, 1'b0, 0, lat);
        chk("lit_ffff_sum", last_sum, 16'h0000);
        chk("lit_ffff_cout", last_cout, 1);
        chk("lit_ffff_cin123", run_cin[3:1], 3'b111);

        do_op(16'h000F, 16'h0000, 1'b1, 0, lat);
        chk("lit_000f_sum", last_sum, 16'h0010);
        chk("lit_000f_cout", last_cout, 0);

        do_op(16'hABCD, 16'h1111, 1'b0, 10, lat);
        chk("lit_hold_sum", last_sum, 16'hBCDE);

        do_op(16'h7FFF, 16'h0001, 1'b0, 0, lat);
        chk("lit_7fff_sum", last_sum, 16'h8000);
        chk("lit_7fff_ovf", last_ovf, OVF_EN);
        do_op(16'h8000, 16'hFFFF, 1'b0, 0, lat);
        chk("lit_8000_ovf", last_ovf, OVF_EN);

        // Reset while RUN is on nibble 2.
        bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; bus.in_cin = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        chk("midrun_add_a", bus.add_a, 4'hF);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", bus.in_ready, 1);
        chk("midrun_rst_out_valid", bus.out_valid, 0);
        chk("midrun_rst_busy", bus.busy, 0);
        chk("midrun_rst_add_cin", bus.add_cin, 0);
        step();
        rst_n = 1'b1;
        step();
        do_op(16'h0001, 16'h0001, 1'b0, 0, lat);
        chk("lit_after_rst_sum", last_sum, 16'h0002);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0: bus.in_a = 16'hFFFF;
                1: bus.in_a = 16'h7FFF;
                2: bus.in_a = 16'h8000;
                default: bus.in_a = 16'($urandom);
            endcase
            bus.in_b      = ($urandom_range(0, 3) == 0) ? 16'hFFFF - bus.in_a : 16'($urandom);
            bus.in_cin    = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.busy && n < 50) begin step(); n++; end
        if (n >= 50) chk("timeout_drain", 1, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
